enemy_fire_scheduler: RTL



---
 rtl/enemy_fire_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: once per shot interval, fires from the front-most
// living invader of an LFSR-chosen column, scanning one alive bit per cycle.
// Ports: clk, reset (sync, active-high), enable, alive, shot_busy
//   -> fire (strobe), shooter_col, shooter_row (held), no_target (pulse).
// Option: define FIRE_SPEEDUP_EN to shorten the interval as invaders die.
module enemy_fire_scheduler #(
  parameter int          LINHAS   = 5,
  parameter int          COLUNAS  = 9,
  parameter int          INTERVAL = 12500000,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [LINHAS*COLUNAS-1:0]  alive,
  input  logic                       shot_busy,
  output logic                       fire,
  output logic [$clog2(COLUNAS)-1:0] shooter_col,
  output logic [$clog2(LINHAS)-1:0]  shooter_row,
  output logic                       no_target
);

  localparam int N  = LINHAS * COLUNAS;
  localparam int CW = $clog2(COLUNAS);
  localparam int RW = $clog2(LINHAS);
  localparam int IW = $clog2(N);
  localparam int KW = $clog2(COLUNAS + 1);
  localparam int TW = $clog2(INTERVAL);

  localparam logic [RW-1:0] TOP_ROW  = RW'(LINHAS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLUNAS - 1);
  localparam logic [KW-1:0] LAST_CHK = KW'(COLUNAS - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT, PICK, SCAN, FIRE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [15:0]   lfsr;
  logic [TW-1:0] cnt;
  logic [TW-1:0] reload;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [KW-1:0] cols_checked;
  logic [CW-1:0] pick_col;
  logic [IW-1:0] bit_idx;
  logic          hit;
  logic          sweep_done;
  logic          nt_set;

`ifdef FIRE_SPEEDUP_EN
  localparam int STEP  = INTERVAL / 64;
  localparam int FLOOR = INTERVAL / 4;

  int dead;
  int cut;

  always_comb begin
    dead = N - $countones(alive);
    cut  = dead * STEP;
    if (INTERVAL - 1 - cut < FLOOR)
      reload = TW'(FLOOR);
    else
      reload = TW'(INTERVAL - 1 - cut);
  end
`else
  assign reload = TW'(INTERVAL - 1);
`endif

  assign pick_col = CW'(32'(lfsr[7:0]) % COLUNAS);
  assign bit_idx  = IW'(32'(row_r) * COLUNAS
                      + 32'(col_r));
  assign hit      = alive[bit_idx];

  // last test of the last unchecked column missed
  assign sweep_done = !hit
                   && (row_r == '0)
                   && (cols_checked == LAST_CHK);

  // free-running Galois LFSR, mask B400
  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= SEED;
    else
      lfsr <= {1'b0, lfsr[15:1]}
            ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nx = WAIT;
        WAIT:
          if (cnt == '0 && !shot_busy)
            state_nx = PICK;
        PICK: state_nx = SCAN;
        SCAN:
          if (hit)
            state_nx = FIRE;
          else if (sweep_done)
            state_nx = WAIT;
        FIRE: state_nx = WAIT;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    fire   = (state == FIRE);
    nt_set = enable
          && (state == SCAN)
          && sweep_done;
  end

  // FIRE reloads on entry and counts as the
  // first cycle of the next interval
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      col_r        <= '0;
      row_r        <= '0;
      cols_checked <= '0;
      shooter_col  <= '0;
      shooter_row  <= '0;
      no_target    <= 1'b0;
    end else begin
      no_target <= nt_set;
      if (enable) begin
        unique case (state)
          IDLE: cnt <= reload;
          WAIT, FIRE:
            if (cnt != '0)
              cnt <= cnt - TW'(1);
          PICK: begin
            col_r        <= pick_col;
            row_r        <= TOP_ROW;
            cols_checked <= '0;
          end
          SCAN: begin
            if (hit) begin
              cnt         <= reload;
              shooter_col <= col_r;
              shooter_row <= row_r;
            end else if (row_r != '0) begin
              row_r <= row_r - RW'(1);
            end else begin
              col_r <= (col_r == LAST_COL)
                     ? '0 : col_r + CW'(1);
              row_r        <= TOP_ROW;
              cols_checked <= cols_checked + KW'(1);
              if (sweep_done)
                cnt <= reload;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
